// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: handshake/data bundle for sync_fifo_param.
//   master : producer/consumer side (drives Clear, DataIn, WrEn, RdEn)
//   slave  : FIFO side (drives data out, status flags, occupancy and error flags)
// Clock and reset are not part of the bundle; they stay plain module ports.
interface sync_fifo_param_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 4
);
   logic                  Clear;
   logic [DATA_WIDTH-1:0] DataIn;
   logic                  WrEn;
   logic                  RdEn;
   logic [DATA_WIDTH-1:0] DataOut;
   logic                  DataValid;
   logic                  Full;
   logic                  Empty;
   logic                  AlmostFull;
   logic                  AlmostEmpty;
   logic [ADDR_WIDTH:0]   Count;
   logic                  OverFlow;
   logic                  UnderFlow;
   logic                  OverFlowSticky;
   logic                  UnderFlowSticky;

   modport master (
      output Clear, DataIn, WrEn, RdEn,
      input  DataOut, DataValid, Full, Empty, AlmostFull, AlmostEmpty, Count,
             OverFlow, UnderFlow, OverFlowSticky, UnderFlowSticky
   );

   modport slave (
      input  Clear, DataIn, WrEn, RdEn,
      output DataOut, DataValid, Full, Empty, AlmostFull, AlmostEmpty, Count,
             OverFlow, UnderFlow, OverFlowSticky, UnderFlowSticky
   );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with occupancy count, programmable
// almost-full/almost-empty flags, synchronous flush, sticky error flags and a
// selectable standard (1-cycle registered read) or first-word-fall-through read mode.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset (priority over everything)
//   bus  : sync_fifo_param_if.slave -- Clear/DataIn/WrEn/RdEn in; DataOut, DataValid,
//          Full, Empty, AlmostFull, AlmostEmpty, Count, OverFlow, UnderFlow and the
//          two sticky error flags out
module sync_fifo_param #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDR_WIDTH    = 4,
   parameter int unsigned AFULL_THRESH  = 12,
   parameter int unsigned AEMPTY_THRESH = 2,
   parameter bit          FWFT          = 1'b0
) (
   input logic                clk,
   input logic                rst,
   sync_fifo_param_if.slave   bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   localparam logic [ADDR_WIDTH:0]   CountOne = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH:0]   CountMax = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   AFullTh  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
   localparam logic [ADDR_WIDTH:0]   AEmptyTh = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);
   localparam logic [ADDR_WIDTH-1:0] PtrOne   = ADDR_WIDTH'(1);

   if (ADDR_WIDTH < 2 || ADDR_WIDTH > 10) begin : gen_bad_addr_width
      $error("sync_fifo_param: ADDR_WIDTH must be in 2..10");
   end
   if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : gen_bad_afull
      $error("sync_fifo_param: AFULL_THRESH must be in 1..DEPTH");
   end
   if (AEMPTY_THRESH > DEPTH - 1) begin : gen_bad_aempty
      $error("sync_fifo_param: AEMPTY_THRESH must be in 0..DEPTH-1");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] wrPtrQ, rdPtrQ;
   logic [ADDR_WIDTH:0]   countQ, countD;
   logic                  fullQ, emptyQ, aFullQ, aEmptyQ;
   logic                  overFlowQ, underFlowQ, overStickyQ, underStickyQ;
   logic                  wrAcc, rdAcc;

   // A full FIFO rejects a write even when a read is accepted in the same cycle.
   always_comb begin
      wrAcc  = bus.WrEn && !fullQ;
      rdAcc  = bus.RdEn && !emptyQ;
      countD = countQ;
      unique case ({wrAcc, rdAcc})
         2'b10:   countD = countQ + CountOne;
         2'b01:   countD = countQ - CountOne;
         default: countD = countQ;
      endcase
   end

   // Memory is deliberately not reset.
   always_ff @(posedge clk) begin
      if (!rst && !bus.Clear && wrAcc) begin
         mem[wrPtrQ] <= bus.DataIn;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || bus.Clear) begin
         wrPtrQ       <= '0;
         rdPtrQ       <= '0;
         countQ       <= '0;
         fullQ        <= 1'b0;
         emptyQ       <= 1'b1;
         aFullQ       <= 1'b0;
         aEmptyQ      <= 1'b1;
         overFlowQ    <= 1'b0;
         underFlowQ   <= 1'b0;
         overStickyQ  <= 1'b0;
         underStickyQ <= 1'b0;
      end else begin
         if (wrAcc) wrPtrQ <= wrPtrQ + PtrOne;
         if (rdAcc) rdPtrQ <= rdPtrQ + PtrOne;
         countQ       <= countD;
         // Flags track the next count so they move on the same edge as Count.
         fullQ        <= (countD == CountMax);
         emptyQ       <= (countD == '0);
         aFullQ       <= (countD >= AFullTh);
         aEmptyQ      <= (countD <= AEmptyTh);
         overFlowQ    <= bus.WrEn && fullQ;
         underFlowQ   <= bus.RdEn && emptyQ;
         overStickyQ  <= overStickyQ || (bus.WrEn && fullQ);
         underStickyQ <= underStickyQ || (bus.RdEn && emptyQ);
      end
   end

   if (FWFT) begin : gen_fwft
      // Head word shown directly; forced to zero while empty so the output is
      // defined after reset even though the memory is not.
      assign bus.DataOut   = emptyQ ? '0 : mem[rdPtrQ];
      assign bus.DataValid = !emptyQ;
   end else begin : gen_std
      logic [DATA_WIDTH-1:0] dataOutQ;
      logic                  dataValidQ;

      // Clear drops DataValid but keeps the last word on DataOut.
      always_ff @(posedge clk) begin
         if (rst) begin
            dataOutQ   <= '0;
            dataValidQ <= 1'b0;
         end else if (bus.Clear) begin
            dataValidQ <= 1'b0;
         end else if (rdAcc) begin
            dataOutQ   <= mem[rdPtrQ];
            dataValidQ <= 1'b1;
         end else begin
            dataValidQ <= 1'b0;
         end
      end

      assign bus.DataOut   = dataOutQ;
      assign bus.DataValid = dataValidQ;
   end

   assign bus.Count           = countQ;
   assign bus.Full            = fullQ;
   assign bus.Empty           = emptyQ;
   assign bus.AlmostFull      = aFullQ;
   assign bus.AlmostEmpty     = aEmptyQ;
   assign bus.OverFlow        = overFlowQ;
   assign bus.UnderFlow       = underFlowQ;
   assign bus.OverFlowSticky  = overStickyQ;
   assign bus.UnderFlowSticky = underStickyQ;
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Single-clock, parametrised FIFO. It is the synchronous successor of the team's dual-clock Gray-pointer FIFO, for blocks that share one clock domain. It generalises data width and depth and adds the following:
- occupancy count
- programmable almost-full and almost-empty flags
- synchronous flush
- sticky error flags
- selectable standard or first-word-fall-through (FWFT) read mode

Parameters:
DATA_WIDTH, 32, width of each stored word.
ADDR_WIDTH, 4, depth is DEPTH = 2**ADDR_WIDTH; legal range 2..10.
AFULL_THRESH, 12, AlmostFull asserts when Count >= AFULL_THRESH; legal range 1..DEPTH.
AEMPTY_THRESH, 2, AlmostEmpty asserts when Count <= AEMPTY_THRESH; legal range 0..DEPTH-1.
FWFT, 0, 0 = standard mode (registered read, 1-cycle latency); 1 = head word visible on DataOut whenever not Empty.

Ports:
clk  in  1  single clock; all logic on rising edge.
rst  in  1  synchronous active-high reset.
Clear  in  1  synchronous flush; empties FIFO, clears sticky flags.
DataIn  in  DATA_WIDTH  write data.
WrEn  in  1  write request.
RdEn  in  1  read request (pop in FWFT mode).
DataOut  out  DATA_WIDTH  read data.
DataValid  out  1  DataOut holds a valid word.
Full  out  1  Count == DEPTH.
Empty  out  1  Count == 0.
AlmostFull  out  1  Count >= AFULL_THRESH.
AlmostEmpty  out  1  Count <= AEMPTY_THRESH.
Count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
OverFlow  out  1  one-cycle pulse: a write was rejected in the previous cycle.
UnderFlow  out  1  one-cycle pulse: a read was rejected in the previous cycle.
OverFlowSticky  out  1  latched OverFlow, held until rst or Clear.
UnderFlowSticky  out  1  latched UnderFlow, held until rst or Clear.

Behaviour:
- Reset (rst=1 at edge):
  - WrPtr, RdPtr and Count go to 0.
  - Empty=1, AlmostEmpty=1, Full=0, AlmostFull=0.
  - DataOut=0, DataValid=0.
  - OverFlow, UnderFlow and both sticky flags go to 0.
  - Memory contents are not reset.
  - rst has priority over Clear, WrEn and RdEn.
- Clear=1 (rst=0): same effect as reset on pointers, Count, flags, sticky flags and DataValid. DataOut holds its value. Any WrEn/RdEn in that cycle is ignored and raises no error pulse.
- Write accept: WrAcc = WrEn && !Full. The word is stored at mem[WrPtr] and WrPtr increments modulo DEPTH (ADDR_WIDTH-bit wrap).
- Read accept: RdAcc = RdEn && !Empty. RdPtr increments modulo DEPTH.
- Full and rejection: a write while Full is rejected even if a read is accepted in the same cycle. There is no pass-through when full.
- Count update: Count <= Count + WrAcc - RdAcc.
  - Simultaneous accepted read and write leaves Count unchanged.
  - Flags are registered and derived from the next Count, so they change on the same edge as Count.
- Error pulses:
  - OverFlow <= WrEn && Full; UnderFlow <= RdEn && Empty.
  - Each is high for one cycle per rejected attempt.
  - Each sticky flag sets with its pulse and stays set.
- Standard mode (FWFT=0):
  - On RdAcc, DataOut <= mem[RdPtr] and DataValid <= 1 on the next edge; otherwise DataValid <= 0 and DataOut holds.
  - Read latency is 1 cycle.
- FWFT mode (FWFT=1):
  - DataOut = mem[RdPtr] continuously; DataValid = !Empty.
  - RdEn pops the current head word.
  - A write into an empty FIFO is visible on DataOut, with DataValid=1, one cycle after the write edge.
- Wrap-around: pointers wrap silently. Count alone distinguishes full from empty when WrPtr == RdPtr.
- Parameter checks: an elaboration-time check fails on out-of-range ADDR_WIDTH, AFULL_THRESH or AEMPTY_THRESH.

Test Plan:
1. Reset, then 16 writes of 0x100..0x10F (DATA_WIDTH=32, ADDR_WIDTH=4), WrEn held high.
   - Count steps 1..16; AlmostEmpty drops when Count=3; AlmostFull rises when Count=12.
   - Full=1 after the 16th edge; a 17th write gives OverFlow=1 for one cycle, OverFlowSticky=1, Count stays 16.
2. FWFT=0, full FIFO from scenario 1, RdEn high for 16 cycles.
   - DataOut is 0x100..0x10F in order, each one cycle after its read edge, with DataValid=1.
   - Empty=1 after the last read; one more RdEn gives UnderFlow=1 for one cycle, UnderFlowSticky=1.
3. Simultaneous WrEn and RdEn for 40 cycles at Count=5.
   - Count stays 5; pointers wrap at least twice; the read sequence matches the write order exactly.
4. Full FIFO, WrEn=1 and RdEn=1 in the same cycle.
   - Read accepted, write rejected; Count becomes 15, OverFlow=1.
5. FWFT=1, write 0xDEAD into an empty FIFO.
   - The next cycle gives DataOut=0xDEAD, DataValid=1, Empty=0.
   - A single RdEn then gives Empty=1, DataValid=0.
6. Count=7 with both sticky flags set; assert Clear together with WrEn.
   - Next cycle: Count=0, Empty=1, sticky flags 0, no OverFlow pulse.
   - Assert rst mid-stream: same result, plus DataOut=0.
